// File: rtl/spi_frame_receiver_pkg.sv
// Shared constants and types for the SPI frame receiver: header bytes,
// payload geometry and the frame FSM state encoding.
package spi_frame_receiver_pkg;

    localparam logic [7:0] HDR0 = 8'h55;
    localparam logic [7:0] HDR1 = 8'hAA;

    localparam int PAYLOAD_BYTES = 20;
    localparam int PAYLOAD_WORDS = PAYLOAD_BYTES / 4;
    localparam int IDX_W         = $clog2(PAYLOAD_BYTES);

    typedef enum logic [1:0] {
        HUNT_H0,
        HUNT_H1,
        PAYLOAD
    } frame_state_t;

    // Assemble a 32-bit word from four bytes, first byte most significant.
    function automatic logic [31:0] be_word(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI byte deserializer: synchronizes sck/cs/miso into sys_clk, detects sck and
// cs rising edges, shifts bits MSB first and flags complete or truncated bytes.
module spi_byte_rx (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       cs,
    input  logic       miso,
    output logic       byte_strobe,
    output logic [7:0] byte_data,
    output logic       partial_abort
);

    localparam int SYNC_W = 3;
    // Bit order {miso, cs, sck}; cs comes out of reset deasserted.
    localparam logic [SYNC_W-1:0] SYNC_IDLE = 3'b010;

    logic [SYNC_W-1:0] pin_async;
    logic [SYNC_W-1:0] sync_bits;

    assign pin_async = {miso, cs, sck};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_W; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge sys_clk) begin
                if (!rst_n) begin
                    meta_reg <= SYNC_IDLE[gi];
                    sync_reg <= SYNC_IDLE[gi];
                end else begin
                    meta_reg <= pin_async[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_bits[gi] = sync_reg;
        end
    endgenerate

    logic       sck_s;
    logic       cs_s;
    logic       miso_s;
    logic       sck_hist_reg;
    logic       cs_hist_reg;
    logic [6:0] shift_reg;
    logic [2:0] bit_cnt_reg;
    logic       sck_rise;
    logic       cs_rise;
    logic       shift_en;

    assign sck_s  = sync_bits[0];
    assign cs_s   = sync_bits[1];
    assign miso_s = sync_bits[2];

    assign sck_rise = sck_s & ~sck_hist_reg;
    assign cs_rise  = cs_s & ~cs_hist_reg;
    assign shift_en = sck_rise & ~cs_s;

    // The completed byte is presented combinationally so the frame logic sees it
    // in the same cycle as the 8th edge.
    assign byte_strobe   = shift_en && (bit_cnt_reg == 3'd7);
    assign byte_data     = {shift_reg, miso_s};
    assign partial_abort = cs_rise && (bit_cnt_reg != 3'd0);

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sck_hist_reg <= 1'b0;
            cs_hist_reg  <= 1'b1;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
        end else begin
            sck_hist_reg <= sck_s;
            cs_hist_reg  <= cs_s;
            if (cs_rise) begin
                bit_cnt_reg <= '0;
            end else if (shift_en) begin
                shift_reg   <= {shift_reg[5:0], miso_s};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
        end
    end

endmodule

// File: rtl/spi_frame_receiver.sv
// Frame layer on top of spi_byte_rx: hunts for the 55 AA header, collects a
// 20-byte big-endian payload and publishes it as five 32-bit words.
module spi_frame_receiver
    import spi_frame_receiver_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        sck,
    input  logic        miso,
    input  logic        cs,
    output logic [31:0] sig_freq_cnt_buf1,
    output logic [31:0] sig_freq_cnt_buf2,
    output logic [31:0] phase_diff_cnt_buf,
    output logic [31:0] sig_in_high_cnt_buf,
    output logic [31:0] sig_in_low_cnt_buf,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PAYLOAD_BYTES - 1);

    logic       byte_strobe;
    logic [7:0] byte_data;
    logic       partial_abort;

    spi_byte_rx u_byte_rx (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .sck           (sck),
        .cs            (cs),
        .miso          (miso),
        .byte_strobe   (byte_strobe),
        .byte_data     (byte_data),
        .partial_abort (partial_abort)
    );

    frame_state_t                        state_reg, state_next;
    logic [IDX_W-1:0]                    idx_reg, idx_next;
    logic [IDLE_W-1:0]                   idle_reg, idle_next;
    logic [PAYLOAD_BYTES-1:0][7:0]       shadow_reg;
    logic                                store_en;
    logic                                commit_reg, commit_next;
    logic                                frame_err_reg, frame_err_next;
    logic                                frame_valid_reg;
    logic [15:0]                         frame_cnt_reg;

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        idle_next      = '0;
        store_en       = 1'b0;
        commit_next    = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            HUNT_H0: begin
                if (byte_strobe && byte_data == HDR0) begin
                    state_next = HUNT_H1;
                end
            end
            HUNT_H1: begin
                if (byte_strobe) begin
                    if (byte_data == HDR1) begin
                        state_next = PAYLOAD;
                        idx_next   = '0;
                    end else if (byte_data != HDR0) begin
                        state_next = HUNT_H0;
                    end
                end
            end
            PAYLOAD: begin
                // Abort and strobe are mutually exclusive: one needs cs high, the other cs low.
                if (partial_abort) begin
                    frame_err_next = 1'b1;
                    state_next     = HUNT_H0;
                end else if (byte_strobe) begin
                    store_en = 1'b1;
                    idx_next = idx_reg + IDX_W'(1);
                    if (idx_reg == IDX_LAST) begin
                        commit_next = 1'b1;
                        state_next  = HUNT_H0;
                    end
                end else if (idle_reg == IDLE_LAST) begin
                    frame_err_next = 1'b1;
                    state_next     = HUNT_H0;
                end else begin
                    idle_next = idle_reg + IDLE_W'(1);
                end
            end
            default: begin
                state_next = HUNT_H0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_reg       <= HUNT_H0;
            idx_reg         <= '0;
            idle_reg        <= '0;
            commit_reg      <= 1'b0;
            frame_err_reg   <= 1'b0;
            frame_valid_reg <= 1'b0;
            frame_cnt_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            idle_reg        <= idle_next;
            commit_reg      <= commit_next;
            frame_err_reg   <= frame_err_next;
            frame_valid_reg <= commit_reg;
            if (commit_reg) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            shadow_reg <= '0;
        end else if (store_en) begin
            shadow_reg[idx_reg] <= byte_data;
        end
    end

    // Output words load only on commit, so an aborted frame never disturbs them.
    logic [31:0] word_q [PAYLOAD_WORDS];

    genvar gi;
    generate
        for (gi = 0; gi < PAYLOAD_WORDS; gi++) begin : g_word
            logic [31:0] word_reg;

            always_ff @(posedge sys_clk) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (commit_reg) begin
                    word_reg <= be_word(shadow_reg[4*gi], shadow_reg[4*gi+1],
                                        shadow_reg[4*gi+2], shadow_reg[4*gi+3]);
                end
            end

            assign word_q[gi] = word_reg;
        end
    endgenerate

    assign sig_freq_cnt_buf1   = word_q[0];
    assign sig_freq_cnt_buf2   = word_q[1];
    assign phase_diff_cnt_buf  = word_q[2];
    assign sig_in_high_cnt_buf = word_q[3];
    assign sig_in_low_cnt_buf  = word_q[4];
    assign frame_valid         = frame_valid_reg;
    assign frame_err           = frame_err_reg;
    assign frame_cnt           = frame_cnt_reg;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Scoreboard bench for spi_frame_receiver: frames are queued as they are sent
// and compared word by word when frame_valid fires.
module tb_spi_frame_receiver;
    import spi_frame_receiver_pkg::*;

    localparam int TIMEOUT = 100;
    localparam int HALF    = 4;   // sck = sys_clk/8

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        sck;
    logic        cs;
    logic        miso;
    logic [31:0] sig_freq_cnt_buf1, sig_freq_cnt_buf2, phase_diff_cnt_buf;
    logic [31:0] sig_in_high_cnt_buf, sig_in_low_cnt_buf;
    logic        frame_valid;
    logic        frame_err;
    logic [15:0] frame_cnt;

    spi_frame_receiver #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .sys_clk             (sys_clk),
        .rst_n               (rst_n),
        .sck                 (sck),
        .miso                (miso),
        .cs                  (cs),
        .sig_freq_cnt_buf1   (sig_freq_cnt_buf1),
        .sig_freq_cnt_buf2   (sig_freq_cnt_buf2),
        .phase_diff_cnt_buf  (phase_diff_cnt_buf),
        .sig_in_high_cnt_buf (sig_in_high_cnt_buf),
        .sig_in_low_cnt_buf  (sig_in_low_cnt_buf),
        .frame_valid         (frame_valid),
        .frame_err           (frame_err),
        .frame_cnt           (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [4:0][31:0] w;
        logic [15:0]      cnt;
    } exp_t;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               valid_cnt = 0;
    int               err_cnt = 0;
    int               err_cyc = 0;
    int               rise_cyc = 0;
    logic [7:0]       pl [PAYLOAD_BYTES];
    logic [15:0]      exp_cnt = '0;
    logic [4:0][31:0] last_words = '0;
    logic [31:0]      got_w [5];

    assign got_w[0] = sig_freq_cnt_buf1;
    assign got_w[1] = sig_freq_cnt_buf2;
    assign got_w[2] = phase_diff_cnt_buf;
    assign got_w[3] = sig_in_high_cnt_buf;
    assign got_w[4] = sig_in_low_cnt_buf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            miso = b[7-i];
            sck  = 1'b0;
            repeat (HALF) @(negedge sys_clk);
            sck      = 1'b1;
            rise_cyc = cyc;
            repeat (HALF) @(negedge sys_clk);
        end
        sck = 1'b0;
        cs  = 1'b1;
        repeat (HALF) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic send_payload(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_byte(pl[i]);
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < PAYLOAD_BYTES; i++) pl[i] = base + 8'(i);
    endtask

    task automatic push_expect();
        exp_t e;
        for (int k = 0; k < 5; k++) e.w[k] = {pl[4*k], pl[4*k+1], pl[4*k+2], pl[4*k+3]};
        exp_cnt = exp_cnt + 16'd1;
        e.cnt   = exp_cnt;
        sb_q.push_back(e);
        last_words = e.w;
    endtask

    task automatic settle_and_drain(input string tag);
        repeat (12) @(negedge sys_clk);
        check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_held(input string tag);
        for (int k = 0; k < 5; k++) check($sformatf("%s_held_w%0d", tag, k), got_w[k], last_words[k]);
    endtask

    // Monitor: one line per received frame or error pulse.
    always @(negedge sys_clk) begin
        if (frame_valid) begin
            exp_t e;
            valid_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                for (int k = 0; k < 5; k++) check($sformatf("frame_w%0d", k), got_w[k], e.w[k]);
                check("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
                check("frame_latency", 32'(cyc - rise_cyc), 32'd4);
                $display("frame_valid: cnt=%0d w0=%08h w4=%08h", frame_cnt, got_w[0], got_w[4]);
            end
        end
        if (frame_err) begin
            err_cnt++;
            err_cyc = cyc;
            $display("frame_err at cycle %0d", cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within 100000 cycles");
        $fatal(1);
    end

    initial begin
        int v0, e0, r3, target;
        rst_n = 1'b0; sck = 1'b0; cs = 1'b1; miso = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        check("rst_w0", got_w[0], 32'd0);
        check("rst_w4", got_w[4], 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        // Basic frame 01..14
        fill(8'h01);
        v0 = valid_cnt;
        send_byte(HDR0); send_byte(HDR1);
        push_expect();
        send_payload(0, 19);
        settle_and_drain("basic");
        check("basic_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        check("basic_buf1", sig_freq_cnt_buf1, 32'h01020304);
        check("basic_buf5", sig_in_low_cnt_buf, 32'h11121314);
        check("basic_cnt", 32'(frame_cnt), 32'd1);

        // 55 55 AA header; payload carries header-like bytes as plain data
        fill(8'h20);
        pl[4] = 8'h55; pl[5] = 8'hAA; pl[6] = 8'h55;
        send_byte(8'h55); send_byte(8'h55); send_byte(8'hAA);
        push_expect();
        send_payload(0, 19);
        settle_and_drain("dbl_hdr");

        // 55 12 AA must not start a frame
        fill(8'h40);
        v0 = valid_cnt;
        send_byte(8'h55); send_byte(8'h12); send_byte(8'hAA);
        send_payload(0, 19);
        repeat (12) @(negedge sys_clk);
        check("bad_hdr_no_valid", 32'(valid_cnt - v0), 32'd0);
        check_held("bad_hdr");

        // Truncated payload byte 7 after 5 bits
        fill(8'h60);
        v0 = valid_cnt; e0 = err_cnt;
        send_byte(HDR0); send_byte(HDR1);
        send_payload(0, 6);
        send_bits(pl[7], 5);
        repeat (12) @(negedge sys_clk);
        check("abort_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("abort_state", 32'(dut.state_reg), 32'(HUNT_H0));
        check_held("abort");
        fill(8'h70);
        send_byte(HDR0); send_byte(HDR1);
        push_expect();
        send_payload(0, 19);
        settle_and_drain("after_abort");

        // Timeout: 150-cycle gap between byte strobes after payload byte 3
        fill(8'h90);
        v0 = valid_cnt; e0 = err_cnt;
        send_byte(HDR0); send_byte(HDR1);
        send_payload(0, 3);
        r3 = rise_cyc;
        repeat (160) @(negedge sys_clk);
        check("timeout_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("timeout_no_valid", 32'(valid_cnt - v0), 32'd0);
        // sync (2) + detect (1) + 99 idle cycles, plus the registered pulse
        check("timeout_latency_ok", 32'((err_cyc - r3 >= 102) && (err_cyc - r3 <= 103)), 32'd1);
        check_held("timeout");

        // 90-cycle gap between byte strobes stays within budget
        e0 = err_cnt;
        send_byte(HDR0); send_byte(HDR1);
        push_expect();
        send_payload(0, 3);
        target = rise_cyc + 90 - 15 * HALF;
        while (cyc < target) @(negedge sys_clk);
        send_payload(4, 19);
        settle_and_drain("stall90");
        check("stall90_no_err", 32'(err_cnt - e0), 32'd0);

        // frame_cnt wraps from 0xFFFF
        force dut.frame_cnt_reg = 16'hFFFF;
        @(negedge sys_clk);
        release dut.frame_cnt_reg;
        exp_cnt = 16'hFFFF;
        fill(8'hB0);
        send_byte(HDR0); send_byte(HDR1);
        push_expect();
        send_payload(0, 19);
        settle_and_drain("wrap");
        check("wrap_cnt", 32'(frame_cnt), 32'd0);

        // Reset mid-frame after payload byte 10
        fill(8'hC0);
        e0 = err_cnt;
        send_byte(HDR0); send_byte(HDR1);
        send_payload(0, 10);
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        for (int k = 0; k < 5; k++) check($sformatf("midrst_w%0d", k), got_w[k], 32'd0);
        check("midrst_cnt", 32'(frame_cnt), 32'd0);
        check("midrst_valid", 32'(frame_valid), 32'd0);
        rst_n = 1'b1;
        exp_cnt = '0;
        last_words = '0;
        repeat (5) @(negedge sys_clk);
        check("midrst_no_err", 32'(err_cnt - e0), 32'd0);
        v0 = valid_cnt;
        send_payload(11, 19);
        repeat (12) @(negedge sys_clk);
        check("midrst_tail_no_valid", 32'(valid_cnt - v0), 32'd0);
        fill(8'hD0);
        send_byte(HDR0); send_byte(HDR1);
        push_expect();
        send_payload(0, 19);
        settle_and_drain("post_rst");
        check("post_rst_cnt", 32'(frame_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_receiver.md
SPI_FRAME_RECEIVER -- requirements
Module: spi_frame_receiver

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1_000_000: the maximum number of sys_clk cycles allowed between payload bytes.
REQ-002 sys_clk  in  1  the single clock; all logic is on its rising edge.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 sck  in  1  SPI serial clock; asynchronous to sys_clk.
REQ-005 miso  in  1  SPI serial data; MSB first; sampled on the sck rising edge.
REQ-006 cs  in  1  SPI chip select; active-low; deasserted between bytes.
REQ-007 sig_freq_cnt_buf1, sig_freq_cnt_buf2, phase_diff_cnt_buf, sig_in_high_cnt_buf, sig_in_low_cnt_buf  out  32 each  the most recent good-frame payload words, in that order.
REQ-008 frame_valid  out  1  one-cycle pulse when the payload words update.
REQ-009 frame_err  out  1  one-cycle pulse when a frame is aborted.
REQ-010 frame_cnt  out  16  count of good frames; wraps from 0xFFFF to 0.

Function
REQ-011 sck, cs and miso SHALL each pass through a 2-flop synchronizer; sck edge detection SHALL use the synchronized value plus one history flop.
REQ-012 Each synchronized sck rising edge seen while synchronized cs is low SHALL shift miso into the LSB of the byte register and increment the bit count (0..7).
REQ-013 The 8th bit SHALL produce a byte strobe in the same cycle, and the bit count SHALL reset to 0.
REQ-014 A synchronized cs rising edge with bit count 1..7 SHALL discard the partial byte and clear the bit count; a count of 0 is benign.
REQ-015 The frame FSM SHALL have the states HUNT_H0, HUNT_H1 and PAYLOAD.
- HUNT_H0: byte 0x55 -> HUNT_H1; any other byte -> stay.
- HUNT_H1: 0xAA -> PAYLOAD with the payload index cleared; 0x55 -> stay; any other byte -> HUNT_H0.
- PAYLOAD: store the byte at the index (0..19), big-endian, into a 160-bit shadow; increment the index.
REQ-016 When the 20th payload byte (index 19) is stored, the FSM SHALL go to HUNT_H0. On the next cycle the module SHALL:
- copy the shadow to the five output words (bytes 0-3 to sig_freq_cnt_buf1, ..., bytes 16-19 to sig_in_low_cnt_buf);
- pulse frame_valid;
- increment frame_cnt.
REQ-017 Latency from the 8th sck rising edge of the last byte at the pin to frame_valid SHALL be 4 sys_clk cycles: 2 for the synchronizer, 1 for edge detect and byte strobe, 1 for the output register.
REQ-018 Output words SHALL change only on frame_valid; an aborted frame SHALL leave them unchanged.
REQ-019 In PAYLOAD, a partial-byte discard (REQ-014) SHALL pulse frame_err and send the FSM to HUNT_H0.
REQ-020 In PAYLOAD, an idle counter SHALL clear on each byte strobe; when it reaches TIMEOUT_CYC-1 without a byte, the module SHALL pulse frame_err and go to HUNT_H0.
REQ-021 In the hunt states, a partial-byte discard SHALL NOT raise frame_err.
REQ-022 A byte of 0x55 received in PAYLOAD SHALL be stored as data; header detection is not re-armed mid-payload.
REQ-023 The receiver SHALL accept back-to-back frames with zero idle bytes between them.

Reset
REQ-024 While rst_n is low at a sys_clk edge, the module SHALL:
- clear all output words, frame_cnt, frame_valid and frame_err to 0;
- clear the bit count, payload index, shadow and idle counter;
- put the FSM in HUNT_H0;
- clear the synchronizer flops, treating sck as 0 and cs as 1.
REQ-025 A reset asserted mid-frame SHALL drop the frame without a frame_err pulse; the first good frame after reset SHALL require a fresh 0x55 0xAA header.

Structure
REQ-026 A shared package SHALL hold:
- HDR0 = 8'h55 and HDR1 = 8'hAA;
- PAYLOAD_BYTES = 20;
- the FSM state enumeration.
REQ-027 One sub-module, spi_byte_rx, SHALL contain the synchronizers, the edge detect, the shift register and the bit count. It exports byte_strobe, byte_data[7:0] and partial_abort.
REQ-028 The frame FSM, idle counter, shadow and output registers SHALL reside in spi_frame_receiver.

Verification
REQ-029 Send 55 AA then 01..14 (hex), one cs window per byte, with sck at sys_clk/8. Required response:
- sig_freq_cnt_buf1 = 0x01020304;
- sig_in_low_cnt_buf = 0x11121314;
- exactly one frame_valid pulse, and frame_cnt = 1.
REQ-030 Send 55 55 AA followed by a 20-byte payload -> the frame is accepted. Send 55 12 AA followed by a payload -> no frame_valid, and the outputs are unchanged.
REQ-031 Raise cs after 5 bits of payload byte 7 -> one frame_err pulse, the outputs are unchanged, and the FSM returns to HUNT_H0; a following good frame is accepted.
REQ-032 Run with TIMEOUT_CYC = 100 and stall 150 cycles after payload byte 3 -> frame_err is pulsed at idle count 99. Stall 90 cycles instead -> the frame completes normally.
REQ-033 Preload frame_cnt to 0xFFFF, then send one good frame -> frame_cnt = 0. Assert rst_n low after payload byte 10 -> no frame_err, and all outputs are 0.
